// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, ready/valid byte FIFO drained LSB first onto serial_out
//   clk, rst        clock; synchronous active-high reset
//   data_in         byte offered by the producer
//   data_in_valid   producer strobe
//   data_in_ready   FIFO can accept a byte (low while rst or full)
//   serial_out      registered UART line, idle high
//   tx_busy         frame in flight or bytes queued
//   fifo_count      bytes queued, not counting the one in the shifter
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = SYMBOL_EDGE_TIME > 1 ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_next;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  // Holds {stop, data}; the start bit is driven directly at load time, so
  // frame bit k (k >= 1) lives at r_frame[k-1].
  logic [8:0] r_frame;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_idx;
  logic r_out;
  logic w_push, w_tc, w_last, w_pop;
  always_comb begin
    data_in_ready = !rst && (r_count != (AW+1)'(FIFO_DEPTH));
    w_push = data_in_valid && data_in_ready;
    w_tc = r_cnt == CW'(SYMBOL_EDGE_TIME - 1);
    w_last = (r_state == SEND) && w_tc && (r_idx == 4'd9);
    w_pop = (r_count != '0) && ((r_state == IDLE) || w_last);
    w_next = (w_pop || (r_state == SEND && !w_last)) ? SEND : IDLE;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_frame <= '1;
      r_cnt <= '0;
      r_idx <= '0;
      r_out <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      // The output is registered, so each edge drives the bit that the
      // counter/index will point at after that edge.
      if (w_pop) begin
        r_frame <= {1'b1, r_mem[r_rptr]};
        r_cnt <= '0;
        r_idx <= '0;
        r_out <= 1'b0;
      end else if (r_state == SEND) begin
        r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        if (w_tc) begin
          r_idx <= r_idx + 1'b1;
          r_out <= w_last ? 1'b1 : r_frame[r_idx];
        end
      end
    end
  end
  assign serial_out = r_out;
  assign tx_busy = (r_state == SEND) || (r_count != '0);
  assign fifo_count = r_count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table-driven bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic data_in_valid = 1'b0;
  logic data_in_ready, serial_out, tx_busy;
  logic [2:0] fifo_count;
  logic [7:0] d_data = 8'h00;
  logic d_valid = 1'b0;
  logic d_ready, d_out, d_busy;
  logic [3:0] d_cnt;
  uart_tx_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .serial_out(serial_out), .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );
  uart_tx_fifo u_def (
    .clk(clk), .rst(rst), .data_in(d_data), .data_in_valid(d_valid),
    .data_in_ready(d_ready), .serial_out(d_out), .tx_busy(d_busy),
    .fifo_count(d_cnt)
  );
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;
  vec_t vecs [4];
  int errors = 0;
  int checks = 0;
  logic [7:0] rxq [$];
  int rst_seen = 0;
  logic [7:0] mon_b;
  logic mon_ok;
  int mon_s;
  always @(posedge clk) if (rst) rst_seen <= rst_seen + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (tx_busy && n < 2000) begin
      tick();
      n++;
    end
    chk({name, " idle timeout"}, 32'(n < 2000), 1);
    repeat (3) tick();
  endtask
  task automatic check_frame(input string tag, input logic [9:0] exp);
    for (int k = 0; k < 10; k++) begin
      repeat (5) tick();
      chk($sformatf("%s bit%0d", tag, k), 32'(serial_out), 32'(exp[k]));
      repeat (5) tick();
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (serial_out === 1'b0 && !rst) begin
        mon_s = rst_seen;
        mon_ok = 1'b1;
        repeat (5) @(negedge clk);
        if (serial_out !== 1'b0) mon_ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clk);
          mon_b[k] = serial_out;
        end
        repeat (10) @(negedge clk);
        if (serial_out !== 1'b1) mon_ok = 1'b0;
        if (mon_ok && mon_s == rst_seen) rxq.push_back(mon_b);
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, nxt, maxc, len;
    logic acc, stall, bad, low;
    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'hA3, 10'b1101000110};
    vecs[2] = '{8'h0F, 10'b1000011110};
    vecs[3] = '{8'h00, 10'b1000000000};
    #1;
    rst = 1'b1;
    repeat (2) tick();
    chk("ready during rst", 32'(data_in_ready), 0);
    chk("reset serial_out", 32'(serial_out), 1);
    chk("reset tx_busy", 32'(tx_busy), 0);
    chk("reset fifo_count", 32'(fifo_count), 0);
    rst = 1'b0;
    #1;
    chk("ready after rst", 32'(data_in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      data_in = vecs[i].data;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
      chk($sformatf("vec%0d count after push", i), 32'(fifo_count), 1);
      chk($sformatf("vec%0d line before pop", i), 32'(serial_out), 1);
      tick();
      chk($sformatf("vec%0d start edge", i), 32'(serial_out), 0);
      chk($sformatf("vec%0d count after pop", i), 32'(fifo_count), 0);
      check_frame($sformatf("vec%0d", i), vecs[i].line);
      chk($sformatf("vec%0d busy after frame", i), 32'(tx_busy), 0);
      chk($sformatf("vec%0d line idle", i), 32'(serial_out), 1);
      repeat (2) tick();
    end
    data_in = 8'hA3;
    data_in_valid = 1'b1;
    tick();
    data_in = 8'h0F;
    tick();
    data_in_valid = 1'b0;
    chk("t2 count during first frame", 32'(fifo_count), 1);
    chk("t2 first start", 32'(serial_out), 0);
    check_frame("t2 A3", 10'b1101000110);
    chk("t2 count after second pop", 32'(fifo_count), 0);
    chk("t2 second start no gap", 32'(serial_out), 0);
    check_frame("t2 0F", 10'b1000011110);
    chk("t2 busy after frames", 32'(tx_busy), 0);
    repeat (3) tick();
    rxq.delete();
    nxt = 1;
    n = 0;
    maxc = 0;
    stall = 1'b0;
    bad = 1'b0;
    data_in = 8'd1;
    data_in_valid = 1'b1;
    while (nxt <= 8 && n < 3000) begin
      acc = data_in_ready;
      if (!acc && fifo_count == 3'd4) stall = 1'b1;
      if (!acc && fifo_count != 3'd4) bad = 1'b1;
      tick();
      n++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (acc) begin
        nxt++;
        data_in = 8'(nxt);
      end
    end
    data_in_valid = 1'b0;
    chk("t3 accept timeout", 32'(n < 3000), 1);
    chk("t3 stalled at full", 32'(stall), 1);
    chk("t3 ready low below full", 32'(bad), 0);
    chk("t3 max fifo_count", 32'(maxc), 4);
    wait_idle("t3");
    chk("t3 rx byte count", 32'(rxq.size()), 8);
    for (int i = 0; i < 8 && i < rxq.size(); i++)
      chk($sformatf("t3 rx byte %0d", i), 32'(rxq[i]), 32'(i + 1));
    rxq.delete();
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(8'h11 + i);
      data_in_valid = 1'b1;
      tick();
    end
    data_in = 8'h99;
    repeat (96) tick();
    chk("t4 count before pop edge", 32'(fifo_count), 4);
    chk("t4 ready at pop edge", 32'(data_in_ready), 0);
    tick();
    data_in_valid = 1'b0;
    chk("t4 count after pop edge", 32'(fifo_count), 3);
    chk("t4 next start", 32'(serial_out), 0);
    wait_idle("t4");
    chk("t4 rx byte count", 32'(rxq.size()), 5);
    for (int i = 0; i < 5 && i < rxq.size(); i++)
      chk($sformatf("t4 rx byte %0d", i), 32'(rxq[i]), 32'(8'h11 + i));
    for (int i = 0; i < 3; i++) begin
      data_in = 8'(8'h21 + i);
      data_in_valid = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
    chk("t5 queued", 32'(fifo_count), 2);
    repeat (12) tick();
    rst = 1'b1;
    #1;
    chk("t5 ready while rst", 32'(data_in_ready), 0);
    tick();
    rst = 1'b0;
    chk("t5 line after rst", 32'(serial_out), 1);
    chk("t5 count after rst", 32'(fifo_count), 0);
    chk("t5 busy after rst", 32'(tx_busy), 0);
    rxq.delete();
    low = 1'b0;
    repeat (300) begin
      tick();
      if (serial_out !== 1'b1) low = 1'b1;
    end
    chk("t5 line stays idle", 32'(low), 0);
    chk("t5 no frames", 32'(rxq.size()), 0);
    chk("t6 ready", 32'(d_ready), 1);
    d_data = 8'hFF;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    chk("t6 count after push", 32'(d_cnt), 1);
    n = 0;
    while (d_out && n < 2000) begin
      tick();
      n++;
    end
    chk("t6 start timeout", 32'(n < 2000), 1);
    len = 0;
    while (!d_out && len < 2000) begin
      tick();
      len++;
    end
    chk("t6 bit period", 32'(len), 434);
    chk("t6 busy in frame", 32'(d_busy), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
